// File: rtl/therm_enc_pkg.sv
// Shared helpers for the flash-ADC thermometer encoder: majority vote, latency math, default width.
package therm_enc_pkg;

    localparam int unsigned NBITS_DFLT = 6;
    localparam int unsigned W          = 2 ** NBITS_DFLT;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Input register + bubble-fix register + one register per REG_EVERY tree levels.
    function automatic int unsigned enc_latency(input int unsigned nbits, input int unsigned reg_every);
        return 2 + (nbits + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/therm_or_tree.sv
// Pipelined OR fat tree: one-hot (or residual multi-hot) word -> OR of hot indices, plus all-zero flag.
module therm_or_tree #(
    parameter int unsigned NBITS     = 6,
    parameter int unsigned REG_EVERY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2**NBITS-1:0]   hot,
    output logic [NBITS-1:0]      code,
    output logic                  zero
);

    localparam int unsigned NW = 1 << NBITS;

    // Each node carries the partial index code of its subtree and a "no bit hot" flag.
    // Tracking "none" instead of "any" lets every pipeline register reset to zero.
    for (genvar l = 0; l <= NBITS; l++) begin : g_lvl
        localparam int unsigned NN = NW >> l;
        logic [NN-1:0]    none;
        logic [NBITS-1:0] part [NN];

        if (l == 0) begin : g_leaf
            assign none = ~hot;
            for (genvar j = 0; j < NN; j++) begin : g_zero
                assign part[j] = '0;
            end
        end else begin : g_node
            localparam logic [NBITS-1:0] BIT = NBITS'(1) << (l - 1);
            logic [NN-1:0]    none_c;
            logic [NBITS-1:0] part_c [NN];

            // The right child holds indices with bit (l-1) set.
            for (genvar j = 0; j < NN; j++) begin : g_pair
                assign none_c[j] = g_lvl[l-1].none[2*j] & g_lvl[l-1].none[2*j+1];
                assign part_c[j] = g_lvl[l-1].part[2*j] | g_lvl[l-1].part[2*j+1]
                                 | (g_lvl[l-1].none[2*j+1] ? '0 : BIT);
            end

            if ((l % REG_EVERY == 0) || (l == NBITS)) begin : g_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        none <= '0;
                        part <= '{default: '0};
                    end else begin
                        none <= none_c;
                        part <= part_c;
                    end
                end
            end else begin : g_comb
                assign none = none_c;
                assign part = part_c;
            end
        end
    end

    assign code = g_lvl[NBITS].part[0];
    assign zero = g_lvl[NBITS].none[0];

endmodule

// File: rtl/therm_enc_pipe.sv
// Flash-ADC back end: bubble-corrected thermometer-to-binary encoder with flags and bubble counter.
module therm_enc_pipe
    import therm_enc_pkg::*;
#(
    parameter int unsigned NBITS     = 6,
    parameter int unsigned REG_EVERY = 2,
    parameter int unsigned CNTW      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2**NBITS-1:0]   in,
    input  logic                  in_vld,
    input  logic                  cnt_clr,
    output logic [NBITS-1:0]      code,
    output logic                  out_vld,
    output logic                  ovr,
    output logic                  udr,
    output logic                  bub,
    output logic [CNTW-1:0]       bub_cnt
);

    localparam int unsigned NW  = 1 << NBITS;
    localparam int unsigned NST = enc_latency(NBITS, REG_EVERY) - 2;

    logic [NW-1:0] s0_t;
    logic          s0_vld;
    logic [NW-1:0] fix_c;
    logic [NW-1:0] hot_c;
    logic [NW-1:0] s1_hot;
    logic          s1_vld;
    logic          s1_ovr;
    logic          s1_bub;
    logic [NST-1:0] vld_dl;
    logic [NST-1:0] ovr_dl;
    logic [NST-1:0] bub_dl;

    // S0: unconditional input capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_t   <= '0;
            s0_vld <= 1'b0;
        end else begin
            s0_t   <= in;
            s0_vld <= in_vld;
        end
    end

    // 3-input majority with edge replication at both ends of the word
    for (genvar i = 0; i < NW; i++) begin : g_fix
        localparam int unsigned LO = (i == 0) ? 0 : i - 1;
        localparam int unsigned HI = (i == NW - 1) ? NW - 1 : i + 1;
        assign fix_c[i] = maj3(s0_t[LO], s0_t[i], s0_t[HI]);
    end

    assign hot_c = fix_c & ~{1'b0, fix_c[NW-1:1]};

    // S1: one-hot and flags of the corrected word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hot <= '0;
            s1_vld <= 1'b0;
            s1_ovr <= 1'b0;
            s1_bub <= 1'b0;
        end else begin
            s1_hot <= hot_c;
            s1_vld <= s0_vld;
            s1_ovr <= &fix_c;
            s1_bub <= |(s0_t ^ fix_c);
        end
    end

    therm_or_tree #(
        .NBITS     (NBITS),
        .REG_EVERY (REG_EVERY)
    ) u_tree (
        .clk   (clk),
        .rst_n (rst_n),
        .hot   (s1_hot),
        .code  (code),
        .zero  (udr)
    );

    // Sideband delay lines matched to the tree pipeline depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_dl <= '0;
            ovr_dl <= '0;
            bub_dl <= '0;
        end else begin
            vld_dl <= NST'({vld_dl, s1_vld});
            ovr_dl <= NST'({ovr_dl, s1_ovr});
            bub_dl <= NST'({bub_dl, s1_bub});
        end
    end

    assign out_vld = vld_dl[NST-1];
    assign ovr     = ovr_dl[NST-1];
    assign bub     = bub_dl[NST-1];

    // Saturating bubble-event counter, clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_cnt <= '0;
        end else if (cnt_clr) begin
            bub_cnt <= '0;
        end else if (out_vld && bub && (bub_cnt != {CNTW{1'b1}})) begin
            bub_cnt <= bub_cnt + CNTW'(1);
        end
    end

endmodule
